// File: rtl/seed_pkg.sv
// seed_pkg: constants and helpers shared across the SEED datapath.
//   SEED_WORD_W / SEED_HALF_W / SEED_BLOCK_W : standard SEED data widths
//   SEED_ROUNDS                              : number of round-function stages
//   cnt_width(n)                             : bits needed to hold 0..n
package seed_pkg;

    localparam int SEED_WORD_W  = 32;
    localparam int SEED_HALF_W  = 64;
    localparam int SEED_BLOCK_W = 128;
    localparam int SEED_ROUNDS  = 16;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seed_pipe_stage.sv
// seed_pipe_stage: one data register plus its valid flop.
//   clk, reset (async, active-high)
//   adv    : capture d_in/v_in on this edge
//   flush  : synchronous clear to RESET_VAL / invalid, wins over adv
//   d_in, v_in   : word and valid tag from the previous stage
//   d_out, v_out : registered word and valid tag
module seed_pipe_stage
    import seed_pkg::*;
#(
    parameter int               WIDTH     = SEED_WORD_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic             flush,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             vld_d, vld_q;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush) begin
            data_d = RESET_VAL;
            vld_d  = 1'b0;
        end else if (adv) begin
            // Data moves even when its valid tag is low; no bubble compaction.
            data_d = d_in;
            vld_d  = v_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VAL;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign d_out = data_q;
    assign v_out = vld_q;

endmodule

// File: rtl/seed_pipe_reg.sv
// seed_pipe_reg: STAGES-deep register chain with per-stage valid tags,
// occupancy count and synchronous flush.
//   clk, reset (async, active-high)
//   clk_en, start, sync : chain advances when clk_en & start & ~sync
//   flush               : clears data, valid bits and count; wins over advance
//   data_in, valid_in   : word and tag captured into stage 0
//   data_out, valid_out : last-stage word and tag
//   count               : number of valid stages (0..STAGES)
//   empty, full         : count == 0 / count == STAGES
// All outputs are decodes of registered state.
module seed_pipe_reg
    import seed_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               STAGES    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CNT_W     = cnt_width(STAGES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic             sync,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic              adv;
    logic [WIDTH-1:0]  stage_data [STAGES];
    logic [STAGES-1:0] stage_vld;
    logic [CNT_W-1:0]  count_d, count_q;

    assign adv = clk_en & start & ~sync;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            seed_pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
                .adv   (adv),
                .flush (flush),
                .d_in  (data_in),
                .v_in  (valid_in),
                .d_out (stage_data[k]),
                .v_out (stage_vld[k])
            );
        end else begin : g_body
            seed_pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
                .adv   (adv),
                .flush (flush),
                .d_in  (stage_data[k-1]),
                .v_in  (stage_vld[k-1]),
                .d_out (stage_data[k]),
                .v_out (stage_vld[k])
            );
        end
    end

    // Occupancy: +1 for a valid word entering, -1 for a valid word dropping
    // off the end. Entering and leaving together cancel, so a full chain
    // fed valid words stays at STAGES and the counter cannot wrap.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (adv) begin
            if (valid_in && !stage_vld[STAGES-1]) begin
                count_d = count_q + CNT_W'(1);
            end else if (!valid_in && stage_vld[STAGES-1]) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign data_out  = stage_data[STAGES-1];
    assign valid_out = stage_vld[STAGES-1];
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(STAGES));

endmodule

// File: doc/seed_pipe_reg.md
# seed_pipe_reg

Parametrised pipeline register chain for the SEED datapath, replacing fixed 32-bit single-stage holding registers. The chain advances one stage per enabled cycle while `sync` is low and holds all contents while `sync` is high. It also tracks per-stage valid bits, an occupancy count and a synchronous flush. It sits between SEED round-function stages and between the key-schedule and the round datapath. Instances range from 32-bit words to 128-bit blocks.

## Interface
- `WIDTH`, default 32: data width per stage; legal values 1..128.
- `STAGES`, default 1: pipeline depth; legal values 1..16.
- `RESET_VAL`, default 0: value loaded into every data stage on reset and on flush.
- `CNT_W`, default $clog2(STAGES+1): occupancy counter width; derived, not overridden.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `clk_en` in 1: global clock enable; when low, the chain and counter hold.
- `start` in 1: datapath run qualifier; when low, the chain and counter hold.
- `sync` in 1: when high, hold; when low, advance (gated by `clk_en` and `start`).
- `flush` in 1: synchronous clear of data, valid bits and count.
- `data_in` in WIDTH: word captured into stage 0.
- `valid_in` in 1: valid tag for `data_in`.
- `data_out` out WIDTH: stage STAGES-1 contents.
- `valid_out` out 1: stage STAGES-1 valid bit.
- `count` out CNT_W: number of valid stages, 0..STAGES.
- `empty` out 1: asserted when `count`==0.
- `full` out 1: asserted when `count`==STAGES.

## Operation
- `adv` = `clk_en` & `start` & ~`sync`.
- **Advance.** On a rising edge with `adv`=1 and `flush`=0:
  - stage0 <= `data_in`, and v0 <= `valid_in`;
  - stage k <= stage k-1, and vk <= vk-1, for k=1..STAGES-1;
  - the word in the last stage is dropped.
- **Hold.** With `adv`=0 and `flush`=0, all stages, valid bits and `count` are unchanged.
- **Data with valid low.** Data still moves with its stage even when its valid bit is 0; there is no bubble compaction.
- **Flush.**
  - On an edge with `flush`=1: all stages <= RESET_VAL, all valid bits <= 0, and `count` <= 0.
  - Flush is independent of `clk_en`, `start` and `sync`.
  - Flush has priority over advance; the simultaneous `data_in` is discarded.
- **Count update on advance.** `count` <= `count` + `valid_in` − v[STAGES-1].
  - The counter must never wrap.
  - At `count`==STAGES with `valid_in`=1, v[STAGES-1] is necessarily 1, so `count` is unchanged.
- **Outputs.** `data_out`, `valid_out`, `empty` and `full` are pure decodes of registered state; there is no combinational path from any input.
- **STAGES=1.** The block behaves as a single register with valid tag, and `count` is either 0 or 1.

## Timing
- **Reset.** Asynchronous assert; all stages = RESET_VAL, all valid bits = 0.
  - Outputs during and after reset: `data_out`=RESET_VAL, `valid_out`=0, `count`=0, `empty`=1, `full`=0.
  - Reset deassertion takes effect at the next rising edge with no extra latency.
- **Reset mid-operation.** In-flight words are lost immediately, without waiting for a clock edge.
- **Latency.** A word presented on an edge with `adv`=1 appears on `data_out` after exactly STAGES advancing edges.
  - Held cycles (`sync`=1, `clk_en`=0 or `start`=0) add latency one-for-one.
  - With continuous `adv`, latency is STAGES cycles.
- **Update timing.** `count`, `empty` and `full` update on the same edge as the stage contents.
- **Throughput.** One word per advancing edge. No backpressure output exists; the upstream controller owns `sync`.

## Structure
- Shared package `seed_pkg`:
  - constants SEED_WORD_W=32, SEED_HALF_W=64, SEED_BLOCK_W=128, SEED_ROUNDS=16;
  - function `cnt_width(n)` returning $clog2(n+1).
- Sub-module `seed_pipe_stage`: one WIDTH-bit data register plus valid flop, with inputs `adv`, `flush` and the async `reset`.
  - `seed_pipe_reg` instantiates STAGES copies in a generate loop.
  - The counter and the `empty`/`full` decode live in the top.

## Test plan
- **Reset and flow.** Assert `reset` mid-clock with STAGES=3, WIDTH=32 → outputs take reset values at once (`data_out`=0, `valid_out`=0, `count`=0, `empty`=1). Then, after release, drive `data_in`=0x11111111, 0x22222222, 0x33333333 with `valid_in`=1 and `adv`=1 → `data_out`=0x11111111 with `valid_out`=1 on the 3rd edge, `full`=1 after the 3rd edge.
- **Hold.** Fill STAGES=3, then raise `sync` for 5 cycles while `data_in` changes → `data_out`, `count` and `full` stay constant. Then lower `sync` → the next word emerges on the following edge.
- **Gating.** With STAGES=2, `clk_en`=0 or `start`=0 while `sync`=0 → no advance. Then restore both → advance resumes with count continuity.
- **Bubbles.** STAGES=4, input valid pattern 1,0,1,1 → `count` sequence 1,1,2,3. Then `valid_in`=0 for 4 cycles → `count` steps down to 0, `empty`=1.
- **Flush priority.** With `flush`=1 and `adv`=1, `valid_in`=1, `data_in`=0xDEADBEEF → after the edge all valid bits = 0, `count`=0, `data_out`=RESET_VAL.
- **Width and depth corners.** WIDTH=128, STAGES=16, `RESET_VAL`=128'hA5..A5: stream 20 valid words → `count` saturates at 16 without wrap, word 0 exits at edge 16, and a flush restores `data_out` to the A5 pattern.
